// File: rtl/maze_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maze_level_ctrl
// Description : Game sequencer for a three-level maze. It sits downstream of
//               the per-level pointer blocks. It picks the active level and
//               pulses that level's pointer reset. It filters the in-path
//               flag into wall hits and runs the scare screen on a hit. It
//               pauses between levels and flags the finished game. It also
//               multiplexes the active level's pixel colour onto the VGA path.
//
// Ports       : clk        in   1  system clock
//               reset      in   1  synchronous, active-high; back to IDLE
//               start      in   1  level-sensitive start request
//               video_on   in   1  active video area
//               lim_in     in   3  bit i = level i pointer fully inside path
//               win_in     in   3  bit i = level i pointer reached goal
//               rgb_in     in   9  [3i+2:3i] = level i pixel colour
//               level      out  2  active level 0..2
//               lvl_reset  out  3  bit i = reset for level i pointer block
//               graph_rgb  out  3  muxed pixel colour (combinational)
//               scare_on   out  1  high while the scare screen runs
//               game_won   out  1  high once all three levels are cleared
//               lives      out  2  remaining lives (0 unless MAZE_LIVES_EN)
//
// Option      : MAZE_LIVES_EN - when defined, a wall hit costs one life.
//               The same level reloads until the lives run out. When
//               undefined, any hit sends the game back to IDLE.
//
// Revision    : 1.0 - initial release
// ============================================================================
module maze_level_ctrl #(
    parameter int LOSE_FILT    = 4,
    parameter int GUARD        = 4,
    parameter int SCARE_CYCLES = 100000000,
    parameter int WIN_CYCLES   = 50000000,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       video_on,
    input  logic [2:0] lim_in,
    input  logic [2:0] win_in,
    input  logic [8:0] rgb_in,
    output logic [1:0] level,
    output logic [2:0] lvl_reset,
    output logic [2:0] graph_rgb,
    output logic       scare_on,
    output logic       game_won,
    output logic [1:0] lives
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GUARD = 3'd2,
        S_PLAY  = 3'd3,
        S_SCARE = 3'd4,
        S_WIN   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int              c_hit_w      = $clog2(LOSE_FILT + 1);
    localparam logic [c_hit_w-1:0] c_hit_max = c_hit_w'(LOSE_FILT);
    localparam logic [26:0]     c_guard_last = 27'(GUARD - 1);
    localparam logic [26:0]     c_scare_last = 27'(SCARE_CYCLES - 1);
    localparam logic [26:0]     c_win_last   = 27'(WIN_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [26:0]          r_cnt;
    logic [c_hit_w-1:0]   r_hit;
    logic [c_hit_w-1:0]   w_hit_nxt;
    logic [1:0]           r_level;
    logic [1:0]           w_level_nxt;
    logic [2:0]           r_lvl_reset;
    logic [2:0]           w_lvl_reset_nxt;
    logic                 r_scare_on;
    logic                 r_game_won;
    logic                 w_lim_cur;
    logic                 w_win_cur;
    logic [2:0]           w_rgb_cur;

`ifdef MAZE_LIVES_EN
    localparam logic [1:0] c_lives_init = 2'(LIVES);
    logic [1:0]           r_lives;
    logic [1:0]           w_lives_nxt;
`endif

    // Flags and colour of the active level only; level 3 never occurs.
    always_comb begin
        w_lim_cur = 1'b0;
        w_win_cur = 1'b0;
        w_rgb_cur = 3'b000;
        case (r_level)
            2'd0: begin w_lim_cur = lim_in[0]; w_win_cur = win_in[0]; w_rgb_cur = rgb_in[2:0]; end
            2'd1: begin w_lim_cur = lim_in[1]; w_win_cur = win_in[1]; w_rgb_cur = rgb_in[5:3]; end
            2'd2: begin w_lim_cur = lim_in[2]; w_win_cur = win_in[2]; w_rgb_cur = rgb_in[8:6]; end
            default: ;
        endcase
    end

    // Next-state logic. The level is forced to 0 whenever IDLE is
    // entered, so a fresh game always starts at the first maze.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_hit_nxt   = '0;
`ifdef MAZE_LIVES_EN
        w_lives_nxt = r_lives;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_level_nxt = 2'd0;
`ifdef MAZE_LIVES_EN
                    w_lives_nxt = c_lives_init;
`endif
                end
            end
            S_LOAD: begin
                w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (r_cnt == c_guard_last) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // Reaching the goal beats a simultaneous wall hit.
                if (w_win_cur) begin
                    w_state_nxt = (r_level < 2'd2) ? S_WIN : S_DONE;
                end else begin
                    if (w_lim_cur) begin
                        w_hit_nxt = '0;
                    end else if (r_hit == c_hit_max) begin
                        w_hit_nxt = r_hit;
                    end else begin
                        w_hit_nxt = r_hit + 1'b1;
                    end
                    if (w_hit_nxt == c_hit_max) begin
                        w_state_nxt = S_SCARE;
                    end
                end
            end
            S_SCARE: begin
                if (r_cnt == c_scare_last) begin
`ifdef MAZE_LIVES_EN
                    w_lives_nxt = r_lives - 2'd1;
                    if (w_lives_nxt != 2'd0) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_level_nxt = 2'd0;
                    end
`else
                    w_state_nxt = S_IDLE;
                    w_level_nxt = 2'd0;
`endif
                end
            end
            S_WIN: begin
                if (r_cnt == c_win_last) begin
                    w_state_nxt = S_LOAD;
                    if (r_level < 2'd2) begin
                        w_level_nxt = r_level + 2'd1;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_IDLE;
                    w_level_nxt = 2'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_level_nxt = 2'd0;
            end
        endcase
    end

    // Pointer resets follow the state being entered. The registered
    // output therefore lines up with the state register.
    always_comb begin
        w_lvl_reset_nxt = 3'b000;
        if (w_state_nxt == S_IDLE) begin
            w_lvl_reset_nxt = 3'b111;
        end else if (w_state_nxt == S_LOAD) begin
            case (w_level_nxt)
                2'd0:    w_lvl_reset_nxt = 3'b001;
                2'd1:    w_lvl_reset_nxt = 3'b010;
                2'd2:    w_lvl_reset_nxt = 3'b100;
                default: w_lvl_reset_nxt = 3'b000;
            endcase
        end
    end

    // One shared timer, cleared on every state change. In the untimed
    // states it free-runs and is never compared.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hit       <= '0;
            r_level     <= 2'd0;
            r_lvl_reset <= 3'b111;
            r_scare_on  <= 1'b0;
            r_game_won  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (w_state_nxt != r_state) ? 27'd0 : r_cnt + 27'd1;
            r_hit       <= w_hit_nxt;
            r_level     <= w_level_nxt;
            r_lvl_reset <= w_lvl_reset_nxt;
            r_scare_on  <= (w_state_nxt == S_SCARE);
            r_game_won  <= (w_state_nxt == S_DONE);
        end
    end

`ifdef MAZE_LIVES_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lives <= c_lives_init;
        end else begin
            r_lives <= w_lives_nxt;
        end
    end
    assign lives = r_lives;
`else
    assign lives = 2'b00;
`endif

    always_comb begin
        if (!video_on) begin
            graph_rgb = 3'b000;
        end else if (r_scare_on) begin
            graph_rgb = 3'b100;
        end else if (r_game_won) begin
            graph_rgb = 3'b010;
        end else if (r_state == S_IDLE) begin
            graph_rgb = 3'b000;
        end else begin
            graph_rgb = w_rgb_cur;
        end
    end

    assign level     = r_level;
    assign lvl_reset = r_lvl_reset;
    assign scare_on  = r_scare_on;
    assign game_won  = r_game_won;

endmodule
`default_nettype wire

// File: tb/tb_maze_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_level_ctrl
// Description : Self-checking bench for maze_level_ctrl. A game-rule model
//               works with countdowns and a streak count. It runs in step
//               with the design. Directed scenarios come first, then a
//               randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_level_ctrl;

    localparam int LF = 4;
    localparam int GD = 4;
    localparam int SC = 8;
    localparam int WC = 8;
    localparam int LV = 3;
`ifdef MAZE_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_LOAD = 1, M_GUARD = 2, M_PLAY = 3,
                   M_SCARE = 4, M_WIN = 5, M_DONE = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       video_on = 1'b1;
    logic [2:0] lim_in = 3'b111;
    logic [2:0] win_in = 3'b000;
    logic [8:0] rgb_in = 9'h000;
    logic [1:0] level;
    logic [2:0] lvl_reset;
    logic [2:0] graph_rgb;
    logic       scare_on;
    logic       game_won;
    logic [1:0] lives;

    int checks = 0;
    int errors = 0;

    // Game-rule model state
    int m_mode   = M_IDLE;
    int m_left   = 0;
    int m_level  = 0;
    int m_lives  = LV;
    int m_streak = 0;

    maze_level_ctrl #(
        .LOSE_FILT   (LF),
        .GUARD       (GD),
        .SCARE_CYCLES(SC),
        .WIN_CYCLES  (WC),
        .LIVES       (LV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .video_on (video_on),
        .lim_in   (lim_in),
        .win_in   (win_in),
        .rgb_in   (rgb_in),
        .level    (level),
        .lvl_reset(lvl_reset),
        .graph_rgb(graph_rgb),
        .scare_on (scare_on),
        .game_won (game_won),
        .lives    (lives)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // One clock of the game rules, applied to the inputs seen at the edge.
    task automatic m_step();
        if (reset) begin
            m_mode = M_IDLE; m_level = 0; m_lives = LV; m_streak = 0; m_left = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (start) begin m_mode = M_LOAD; m_level = 0; m_lives = LV; end
            M_LOAD: begin m_mode = M_GUARD; m_left = GD; end
            M_GUARD: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_PLAY; m_streak = 0; end
            end
            M_PLAY: begin
                if (win_in[m_level]) begin
                    m_mode = (m_level < 2) ? M_WIN : M_DONE;
                    m_left = WC;
                end else begin
                    m_streak = lim_in[m_level] ? 0 : ((m_streak + 1 > LF) ? LF : m_streak + 1);
                    if (m_streak == LF) begin m_mode = M_SCARE; m_left = SC; end
                end
            end
            M_SCARE: begin
                m_left--;
                if (m_left == 0) begin
                    if (LIVES_EN) begin
                        m_lives--;
                        if (m_lives > 0) m_mode = M_LOAD;
                        else begin m_mode = M_IDLE; m_level = 0; end
                    end else begin
                        m_mode = M_IDLE; m_level = 0;
                    end
                end
            end
            M_WIN: begin
                m_left--;
                if (m_left == 0) begin m_level++; m_mode = M_LOAD; end
            end
            M_DONE: if (start) begin m_mode = M_IDLE; m_level = 0; end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [2:0] e_lvl_reset();
        if (m_mode == M_IDLE) return 3'b111;
        if (m_mode == M_LOAD) return 3'b001 << m_level;
        return 3'b000;
    endfunction

    function automatic logic [2:0] e_rgb();
        if (!video_on) return 3'b000;
        if (m_mode == M_SCARE) return 3'b100;
        if (m_mode == M_DONE) return 3'b010;
        if (m_mode == M_IDLE) return 3'b000;
        return rgb_in[3*m_level +: 3];
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    // Drives the game into PLAY from IDLE/LOAD/GUARD with clean inputs.
    task automatic to_play();
        int n = 0;
        lim_in = 3'b111; win_in = 3'b000;
        while (m_mode != M_PLAY && n < 50) begin
            start = (m_mode == M_IDLE);
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= 50) begin
            errors++;
            $display("FAIL to_play_timeout mode=%0d", m_mode);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; video_on = 1'b1; lim_in = 3'b111; win_in = 3'b000;
        rgb_in = 9'h1A5;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (lvl_reset !== 3'b111) begin errors++; $display("FAIL reset_lvl_reset got %b want 111", lvl_reset); end
        checks++; if (graph_rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb got %b want 000", graph_rgb); end
        checks++; if (scare_on !== 1'b0) begin errors++; $display("FAIL reset_scare got %b want 0", scare_on); end
        checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL reset_won got %b want 0", game_won); end
        checks++; if (lives !== (LIVES_EN ? 2'd3 : 2'd0)) begin errors++; $display("FAIL reset_lives got %0d", lives); end
    endtask

    task automatic test_start_guard();
        rgb_in = 9'o765;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (lvl_reset !== 3'b001) begin errors++; $display("FAIL load_pulse got %b want 001", lvl_reset); end
        tick();
        checks++; if (lvl_reset !== 3'b000) begin errors++; $display("FAIL guard_lvl_reset got %b want 000", lvl_reset); end
        for (int i = 0; i < GD; i++) tick();
        checks++; if (graph_rgb !== 3'o5) begin errors++; $display("FAIL play_rgb got %b want 101", graph_rgb); end
        video_on = 1'b0; #1;
        checks++; if (graph_rgb !== 3'b000) begin errors++; $display("FAIL blank_rgb got %b want 000", graph_rgb); end
        video_on = 1'b1;
    endtask

    // Entered in PLAY at level 0, directly after the guard window.
    task automatic test_hit();
        int n;
        lim_in = 3'b110;
        for (int i = 0; i < LF - 1; i++) tick();
        lim_in = 3'b111;
        tick(); tick();
        checks++; if (scare_on !== 1'b0) begin errors++; $display("FAIL short_glitch_scare got %b want 0", scare_on); end
        lim_in = 3'b110;
        for (int i = 0; i < LF - 1; i++) tick();
        checks++; if (scare_on !== 1'b0) begin errors++; $display("FAIL pre_hit_scare got %b want 0", scare_on); end
        tick();
        lim_in = 3'b111;
        checks++; if (scare_on !== 1'b1) begin errors++; $display("FAIL hit_scare got %b want 1", scare_on); end
        checks++; if (graph_rgb !== 3'b100) begin errors++; $display("FAIL scare_rgb got %b want 100", graph_rgb); end
        n = 1;
        while (n < 40) begin
            tick();
            if (!scare_on) break;
            n++;
        end
        checks++; if (n != SC) begin errors++; $display("FAIL scare_len got %0d want %0d", n, SC); end
        checks++; if (lvl_reset !== (LIVES_EN ? 3'b001 : 3'b111)) begin errors++; $display("FAIL scare_exit_reset got %b", lvl_reset); end
        checks++; if (lives !== (LIVES_EN ? 2'd2 : 2'd0)) begin errors++; $display("FAIL scare_exit_lives got %0d", lives); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL scare_exit_level got %0d want 0", level); end
    endtask

    task automatic test_win_priority();
        to_play();
        lim_in = 3'b110;
        for (int i = 0; i < LF - 1; i++) tick();
        win_in = 3'b001;
        tick();
        win_in = 3'b000; lim_in = 3'b111;
        for (int i = 0; i < WC - 1; i++) begin
            checks++; if (scare_on !== 1'b0) begin errors++; $display("FAIL win_prio_scare cyc %0d got %b want 0", i, scare_on); end
            tick();
        end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL win_hold_level got %0d want 0", level); end
        tick();
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL win_next_level got %0d want 1", level); end
        checks++; if (lvl_reset !== 3'b010) begin errors++; $display("FAIL win_load_pulse got %b want 010", lvl_reset); end
    endtask

    // Entered in LOAD of level 1.
    task automatic test_full_game();
        to_play();
        win_in = 3'b010; tick(); win_in = 3'b000;
        checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL lvl1_won got %b want 0", game_won); end
        for (int i = 0; i < WC; i++) tick();
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL lvl2_level got %0d want 2", level); end
        to_play();
        win_in = 3'b100; tick(); win_in = 3'b000;
        checks++; if (game_won !== 1'b1) begin errors++; $display("FAIL done_won got %b want 1", game_won); end
        checks++; if (graph_rgb !== 3'b010) begin errors++; $display("FAIL done_rgb got %b want 010", graph_rgb); end
        tick(); tick();
        checks++; if (game_won !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", game_won); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL done_exit_level got %0d want 0", level); end
        checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL done_exit_won got %b want 0", game_won); end
        checks++; if (lvl_reset !== 3'b111) begin errors++; $display("FAIL done_exit_reset got %b want 111", lvl_reset); end
    endtask

    task automatic test_reset_mid();
        to_play();
        lim_in = 3'b110;
        for (int i = 0; i < LF; i++) tick();
        lim_in = 3'b111;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (scare_on !== 1'b0) begin errors++; $display("FAIL mid_scare_scare got %b want 0", scare_on); end
        checks++; if (lvl_reset !== 3'b111) begin errors++; $display("FAIL mid_scare_reset got %b want 111", lvl_reset); end
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (lvl_reset !== 3'b111) begin errors++; $display("FAIL mid_guard_reset got %b want 111", lvl_reset); end
        tick();
        checks++; if (lvl_reset !== 3'b111) begin errors++; $display("FAIL post_reset_idle got %b want 111", lvl_reset); end
        to_play();
        win_in = 3'b001; tick(); win_in = 3'b000;
        for (int i = 0; i < WC - 1; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL mid_win_level got %0d want 0", level); end
        checks++; if (lvl_reset !== 3'b111) begin errors++; $display("FAIL mid_win_reset got %b want 111", lvl_reset); end
    endtask

    // Entered in IDLE with a fresh life count.
    task automatic test_lives();
        int n;
        for (int h = 1; h <= LV; h++) begin
            to_play();
            lim_in = 3'b110;
            for (int i = 0; i < LF; i++) tick();
            lim_in = 3'b111;
            n = 0;
            while (scare_on && n < 30) begin tick(); n++; end
            checks++;
            if (lives !== (LIVES_EN ? 2'(LV - h) : 2'd0)) begin
                errors++; $display("FAIL lives_hit%0d got %0d", h, lives);
            end
            checks++;
            if (lvl_reset !== ((LIVES_EN && h < LV) ? 3'b001 : 3'b111)) begin
                errors++; $display("FAIL lives_exit%0d got %b", h, lvl_reset);
            end
        end
    endtask

    task automatic test_random();
        bit bad = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 7) == 0);
            video_on = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bad = ~bad;
            if (bad) lim_in = ($urandom_range(0, 4) == 0) ? 3'b111 : 3'b000;
            else     lim_in = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            win_in = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            rgb_in = 9'($urandom_range(0, 511));
            tick();
            checks++; if (level !== 2'(m_level)) begin errors++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, m_level); end
            checks++; if (lvl_reset !== e_lvl_reset()) begin errors++; $display("FAIL rnd_lvl_reset c=%0d got %b want %b", c, lvl_reset, e_lvl_reset()); end
            checks++; if (scare_on !== (m_mode == M_SCARE)) begin errors++; $display("FAIL rnd_scare c=%0d got %b", c, scare_on); end
            checks++; if (game_won !== (m_mode == M_DONE)) begin errors++; $display("FAIL rnd_won c=%0d got %b", c, game_won); end
            checks++; if (lives !== (LIVES_EN ? 2'(m_lives) : 2'd0)) begin errors++; $display("FAIL rnd_lives c=%0d got %0d want %0d", c, lives, m_lives); end
            checks++; if (graph_rgb !== e_rgb()) begin errors++; $display("FAIL rnd_rgb c=%0d got %b want %b", c, graph_rgb, e_rgb()); end
        end
        reset = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_guard();
        test_hit();
        test_win_priority();
        test_full_game();
        test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        test_lives();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
